ascii_to_morse_tx: RTL and testbench
====================================

Name: ascii_to_morse_tx

Overview:
Transmit-side counterpart of the button-to-morse/decoder path. Accepts one ASCII character per handshake and drives a single keying line (LED/buzzer) with standard Morse timing. The timing is measured in units of UNIT_CYCLES clocks and matches the receive-side conventions: dot 1 unit, dash 3, intra-letter gap 1, letter gap 3, word gap 7. It sits between the character source (trainer prompt logic) and the board LED/buzzer pin.

Parameters:
UNIT_CYCLES, 1, clock cycles per Morse time unit (≥1)
CNT_W, $clog2(7*UNIT_CYCLES+1), width of the internal unit/cycle counter (derived; do not override)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
ascii_char  input  8  character to send; sampled on accept
char_valid  input  1  source has a character on ascii_char
char_ready  output  1  high only in IDLE; accept = char_valid & char_ready at a rising edge
key_out  output  1  Morse keying line, 1 = tone/LED on
busy  output  1  high in every state except IDLE
invalid_char  output  1  one-cycle pulse when an accepted char has no Morse code
morse_index  output  3  index (0-4) of the symbol currently being keyed; 0 when idle

Behaviour:
- Reset (reset=0, async): state=IDLE, key_out=0, busy=0, invalid_char=0, morse_index=0, counter=0, symbol regs=SYM_NONE. char_ready=1 once reset is released. A reset mid-character aborts immediately; key_out drops asynchronously.
- Symbol encoding: 2'b00 none, 2'b01 dot, 2'b10 dash. Each code is up to 5 symbols, packed first-symbol-first, with a length 0-5.
- Supported characters:
  - A-Z (0x41-0x5A), with a-z (0x61-0x7A) folded to upper case.
  - 0-9 (0x30-0x39), 5 symbols each.
  - Space (0x20): word gap.
  - Anything else is invalid.
- States: IDLE, LOAD, MARK, GAP_SYM, GAP_LETTER, GAP_WORD.
- IDLE: on accept (edge T), register the lookup result and go to LOAD. For space, go to GAP_WORD. For an invalid char, assert invalid_char for the cycle after T and stay in IDLE; char_ready stays high.
- LOAD: one cycle with key_out=0. Go to MARK with counter = 1*UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash) for symbol 0. Total accept-to-key latency is 2 edges (key_out=1 from edge T+2).
- MARK: key_out=1 and counter decrements each cycle. At counter==1:
  - More symbols remain: go to GAP_SYM with counter=UNIT_CYCLES.
  - Otherwise: go to GAP_LETTER with counter=3*UNIT_CYCLES.
- GAP_SYM: key_out=0. At expiry, increment morse_index and enter MARK for the next symbol.
- GAP_LETTER: key_out=0 for 3 units, then IDLE.
- GAP_WORD: key_out=0 for 7*UNIT_CYCLES, then IDLE. Combined with the preceding letter gap this gives 10 units; that is intentional and the trainer relies on it.
- key_out is registered and glitch-free. Its only transitions are MARK entry and MARK exit.
- char_valid asserted while busy is ignored, not queued. The source must hold it until accepted.
- ascii_char changes after accept have no effect on the character in flight.

Decomposition:
- morse_pkg:
  - SYM_NONE/SYM_DOT/SYM_DASH localparams.
  - Unit multipliers DOT_U=1, DASH_U=3, GAP_SYM_U=1, GAP_LTR_U=3, GAP_WORD_U=7.
  - State encoding.
- Sub-module morse_encoder_lut (combinational): ascii[7:0] → sym0..sym4 (2b each), len[2:0], is_space, is_valid. It must be the exact inverse of the table in morse_decoder so both directions share one truth source.

Test Plan:
(UNIT_CYCLES=1 unless stated)
- 'E' 0x45 accepted at edge T → key_out=1 for exactly 1 cycle starting T+2, then low 3 cycles; char_ready high again at T+6; morse_index stays 0.
- 'S' 0x53 → key pattern 1,0,1,0,1 then 0,0,0; morse_index steps 0,1,2. Lowercase 's' 0x73 gives an identical waveform.
- 'T' 0x54 with UNIT_CYCLES=4 → key_out high exactly 12 cycles, then low 12 cycles before char_ready.
- '0' 0x30 → five 3-cycle marks separated by 1-cycle gaps (19 cycles from first mark rise to last mark fall); busy high throughout.
- Space 0x20 → no key activity, busy for 7 cycles. '?' 0x3F → invalid_char pulses 1 cycle, key_out stays 0, char_ready never drops.
- Reset driven low mid-dash of 'T' → key_out=0 and busy=0 immediately (asynchronous). After release, 'E' transmits normally with no residue from 'T'.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse symbol encoding, timing multipliers, FSM states and the
// pattern-packing helpers used by the encoder lookup table.
package morse_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  localparam int DOT_U      = 1;
  localparam int DASH_U     = 3;
  localparam int GAP_SYM_U  = 1;
  localparam int GAP_LTR_U  = 3;
  localparam int GAP_WORD_U = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MARK,
    ST_GAP_SYM,
    ST_GAP_LETTER,
    ST_GAP_WORD
  } state_t;

  // pat is written left-to-right as keyed (1 = dash); the first symbol sits
  // at bit n-1. Result is {len[2:0], sym4..sym0} with sym0 keyed first.
  function automatic logic [12:0] morse_code(input logic [2:0] n, input logic [4:0] pat);
    logic [9:0] s;
    s = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < int'(n)) s[2*i +: 2] = pat[3'(int'(n) - 1 - i)] ? SYM_DASH : SYM_DOT;
    end
    return {n, s};
  endfunction

  // Digits 1-5 lead with d dots, 6-9 lead with d-5 dashes, 0 is all dashes.
  function automatic logic [12:0] digit_code(input logic [3:0] d);
    logic [4:0] pat;
    if (d <= 4'd5) pat = 5'b11111 >> d;
    else           pat = ~(5'b11111 >> (d - 4'd5));
    return morse_code(3'd5, pat);
  endfunction

endpackage

// File: rtl/morse_encoder_lut.sv
// Combinational ASCII -> Morse lookup; the mirror image of the decoder table.
module morse_encoder_lut
  import morse_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [1:0] sym0,
  output logic [1:0] sym1,
  output logic [1:0] sym2,
  output logic [1:0] sym3,
  output logic [1:0] sym4,
  output logic [2:0] len,
  output logic       is_space,
  output logic       is_valid
);

  logic [7:0] up;
  logic [9:0] syms;

  always_comb begin
    up = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A) up = ascii - 8'h20;
    syms     = '0;
    len      = '0;
    is_space = 1'b0;
    is_valid = 1'b1;
    case (up)
      8'h20: is_space = 1'b1;
      "A": {len, syms} = morse_code(3'd2, 5'b00001);
      "B": {len, syms} = morse_code(3'd4, 5'b01000);
      "C": {len, syms} = morse_code(3'd4, 5'b01010);
      "D": {len, syms} = morse_code(3'd3, 5'b00100);
      "E": {len, syms} = morse_code(3'd1, 5'b00000);
      "F": {len, syms} = morse_code(3'd4, 5'b00010);
      "G": {len, syms} = morse_code(3'd3, 5'b00110);
      "H": {len, syms} = morse_code(3'd4, 5'b00000);
      "I": {len, syms} = morse_code(3'd2, 5'b00000);
      "J": {len, syms} = morse_code(3'd4, 5'b00111);
      "K": {len, syms} = morse_code(3'd3, 5'b00101);
      "L": {len, syms} = morse_code(3'd4, 5'b00100);
      "M": {len, syms} = morse_code(3'd2, 5'b00011);
      "N": {len, syms} = morse_code(3'd2, 5'b00010);
      "O": {len, syms} = morse_code(3'd3, 5'b00111);
      "P": {len, syms} = morse_code(3'd4, 5'b00110);
      "Q": {len, syms} = morse_code(3'd4, 5'b01101);
      "R": {len, syms} = morse_code(3'd3, 5'b00010);
      "S": {len, syms} = morse_code(3'd3, 5'b00000);
      "T": {len, syms} = morse_code(3'd1, 5'b00001);
      "U": {len, syms} = morse_code(3'd3, 5'b00001);
      "V": {len, syms} = morse_code(3'd4, 5'b00001);
      "W": {len, syms} = morse_code(3'd3, 5'b00011);
      "X": {len, syms} = morse_code(3'd4, 5'b01001);
      "Y": {len, syms} = morse_code(3'd4, 5'b01011);
      "Z": {len, syms} = morse_code(3'd4, 5'b01100);
      default: begin
        if (up >= 8'h30 && up <= 8'h39) {len, syms} = digit_code(up[3:0]);
        else is_valid = 1'b0;
      end
    endcase
    sym0 = syms[1:0];
    sym1 = syms[3:2];
    sym2 = syms[5:4];
    sym3 = syms[7:6];
    sym4 = syms[9:8];
  end

endmodule

// File: rtl/ascii_to_morse_tx.sv
// Morse transmitter: takes one ASCII character per handshake and keys a
// single LED/buzzer line with unit-based dot/dash/gap timing.
module ascii_to_morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1,
  parameter int CNT_W       = $clog2(7*UNIT_CYCLES+1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ascii_char,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       invalid_char,
  output logic [2:0] morse_index
);

  localparam logic [CNT_W-1:0] DOT_C   = CNT_W'(DOT_U * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DASH_C  = CNT_W'(DASH_U * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GSYM_C  = CNT_W'(GAP_SYM_U * UNIT_CYCLES);
  // key_out trails MARK by one register stage, so the letter gap holds one
  // extra cycle to keep the line low for a full 3 units before ready.
  localparam logic [CNT_W-1:0] GLTR_C  = CNT_W'(GAP_LTR_U * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] GWORD_C = CNT_W'(GAP_WORD_U * UNIT_CYCLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0][1:0]  syms_q, syms_n;
  logic [2:0]       len_q, len_n;
  logic [2:0]       idx, idx_n, idx_inc;
  logic             inv_n;

  logic [4:0][1:0]  lut_syms;
  logic [2:0]       lut_len;
  logic             lut_space, lut_valid;

  morse_encoder_lut u_lut (
    .ascii    (ascii_char),
    .sym0     (lut_syms[0]),
    .sym1     (lut_syms[1]),
    .sym2     (lut_syms[2]),
    .sym3     (lut_syms[3]),
    .sym4     (lut_syms[4]),
    .len      (lut_len),
    .is_space (lut_space),
    .is_valid (lut_valid)
  );

  function automatic logic [CNT_W-1:0] mark_cycles(input logic [1:0] s);
    return (s == SYM_DASH) ? DASH_C : DOT_C;
  endfunction

  assign char_ready  = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign morse_index = idx;
  assign idx_inc     = idx + 3'd1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    syms_n  = syms_q;
    len_n   = len_q;
    idx_n   = idx;
    inv_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (char_valid) begin
          if (!lut_valid) begin
            inv_n = 1'b1;
          end else if (lut_space) begin
            state_n = ST_GAP_WORD;
            cnt_n   = GWORD_C;
          end else begin
            state_n = ST_LOAD;
            syms_n  = lut_syms;
            len_n   = lut_len;
            idx_n   = 3'd0;
          end
        end
      end
      ST_LOAD: begin
        state_n = ST_MARK;
        cnt_n   = mark_cycles(syms_q[0]);
      end
      ST_MARK: begin
        if (cnt == CNT_W'(1)) begin
          if (idx_inc < len_q) begin
            state_n = ST_GAP_SYM;
            cnt_n   = GSYM_C;
          end else begin
            state_n = ST_GAP_LETTER;
            cnt_n   = GLTR_C;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_GAP_SYM: begin
        if (cnt == CNT_W'(1)) begin
          state_n = ST_MARK;
          idx_n   = idx_inc;
          cnt_n   = mark_cycles(syms_q[idx_inc]);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_GAP_LETTER, ST_GAP_WORD: begin
        if (cnt == CNT_W'(1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          idx_n   = 3'd0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        idx_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      syms_q       <= {5{SYM_NONE}};
      len_q        <= '0;
      idx          <= '0;
      key_out      <= 1'b0;
      invalid_char <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      syms_q       <= syms_n;
      len_q        <= len_n;
      idx          <= idx_n;
      key_out      <= (state == ST_MARK);
      invalid_char <= inv_n;
    end
  end

endmodule

// File: tb/tb_ascii_to_morse_tx.sv
// Directed bench for ascii_to_morse_tx: one DUT at UNIT_CYCLES=1, one at 4.
module tb_ascii_to_morse_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ascii_char = 8'h00;
  logic       char_valid = 1'b0;
  logic       sel = 1'b0;

  logic       rdy1, key1, busy1, inv1;
  logic [2:0] idx1;
  logic       rdy4, key4, busy4, inv4;
  logic [2:0] idx4;
  logic       rdy, key, busy, inv;
  logic [2:0] idx;

  int vecs = 0;
  int errs = 0;

  logic [63:0] s_key, s_rdy, s_busy, s_inv;
  logic [2:0]  s_idx [64];

  always #5 clock = ~clock;

  ascii_to_morse_tx #(.UNIT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .ascii_char(ascii_char),
    .char_valid(char_valid & ~sel), .char_ready(rdy1), .key_out(key1),
    .busy(busy1), .invalid_char(inv1), .morse_index(idx1)
  );

  ascii_to_morse_tx #(.UNIT_CYCLES(4)) dut4 (
    .clock(clock), .reset(reset), .ascii_char(ascii_char),
    .char_valid(char_valid & sel), .char_ready(rdy4), .key_out(key4),
    .busy(busy4), .invalid_char(inv4), .morse_index(idx4)
  );

  assign rdy  = sel ? rdy4  : rdy1;
  assign key  = sel ? key4  : key1;
  assign busy = sel ? busy4 : busy1;
  assign inv  = sel ? inv4  : inv1;
  assign idx  = sel ? idx4  : idx1;

  // Called in the negedge phase; returns just after the accepting edge T.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (!rdy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      vecs++; errs++;
      $display("FAIL send_timeout char=%h ready never rose", c);
    end
    ascii_char = c;
    char_valid = 1'b1;
    @(posedge clock);
    #1;
    char_valid = 1'b0;
    ascii_char = 8'hFF;
  endtask

  // Sample k is the value during the cycle following edge T+k.
  task automatic capture(input int n);
    s_key = '0; s_rdy = '0; s_busy = '0; s_inv = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      s_key[k]  = key;
      s_rdy[k]  = rdy;
      s_busy[k] = busy;
      s_inv[k]  = inv;
      s_idx[k]  = idx;
    end
  endtask

  task automatic test_reset();
    #12;
    vecs++;
    if ({key1, busy1, inv1, idx1, key4, busy4} !== 8'h00) begin
      errs++;
      $display("FAIL reset_outputs got %b exp 00000000", {key1, busy1, inv1, idx1, key4, busy4});
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vecs++;
    if ({rdy1, rdy4} !== 2'b11) begin
      errs++;
      $display("FAIL reset_ready got %b exp 11", {rdy1, rdy4});
    end
  endtask

  task automatic test_letter_e();
    sel = 1'b0;
    send(8'h45);
    capture(7);
    vecs++;
    if (s_key[6:0] !== 7'b0000100) begin
      errs++; $display("FAIL E_key got %b exp 0000100", s_key[6:0]);
    end
    vecs++;
    if (s_rdy[6:0] !== 7'b1000000) begin
      errs++; $display("FAIL E_ready got %b exp 1000000", s_rdy[6:0]);
    end
    vecs++;
    if (s_busy[6:0] !== 7'b0111111) begin
      errs++; $display("FAIL E_busy got %b exp 0111111", s_busy[6:0]);
    end
    vecs++;
    if ({s_idx[0], s_idx[2], s_idx[4], s_idx[6]} !== 12'h000) begin
      errs++; $display("FAIL E_index got %h exp 000", {s_idx[0], s_idx[2], s_idx[4], s_idx[6]});
    end
  endtask

  task automatic test_letter_s();
    sel = 1'b0;
    send(8'h53);
    capture(11);
    vecs++;
    if (s_key[10:0] !== 11'b00001010100) begin
      errs++; $display("FAIL S_key got %b exp 00001010100", s_key[10:0]);
    end
    vecs++;
    if ({s_idx[2], s_idx[4], s_idx[6], s_idx[10]} !== {3'd0, 3'd1, 3'd2, 3'd0}) begin
      errs++; $display("FAIL S_index got %h exp %h", {s_idx[2], s_idx[4], s_idx[6], s_idx[10]},
                       {3'd0, 3'd1, 3'd2, 3'd0});
    end
    vecs++;
    if (s_rdy[10:0] !== 11'b10000000000) begin
      errs++; $display("FAIL S_ready got %b exp 10000000000", s_rdy[10:0]);
    end
    send(8'h73);
    capture(11);
    vecs++;
    if (s_key[10:0] !== 11'b00001010100) begin
      errs++; $display("FAIL s_lower_key got %b exp 00001010100", s_key[10:0]);
    end
  endtask

  task automatic test_unit4_t();
    int highs;
    sel = 1'b1;
    @(negedge clock);
    send(8'h54);
    capture(27);
    highs = 0;
    for (int k = 0; k < 27; k++) if (s_key[k]) highs++;
    vecs++;
    if (highs != 12) begin
      errs++; $display("FAIL T4_high_cycles got %0d exp 12", highs);
    end
    vecs++;
    if (s_key[26:0] !== 27'h0003FFC) begin
      errs++; $display("FAIL T4_key got %h exp 0003ffc", s_key[26:0]);
    end
    vecs++;
    if (s_rdy[26:0] !== 27'h4000000) begin
      errs++; $display("FAIL T4_ready got %h exp 4000000", s_rdy[26:0]);
    end
    sel = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_digit_zero();
    sel = 1'b0;
    send(8'h30);
    capture(25);
    vecs++;
    if (s_key[24:0] !== 25'h01DDDDC) begin
      errs++; $display("FAIL zero_key got %h exp 01ddddc", s_key[24:0]);
    end
    vecs++;
    if (s_busy[24:0] !== 25'h0FFFFFF) begin
      errs++; $display("FAIL zero_busy got %h exp 0ffffff", s_busy[24:0]);
    end
    vecs++;
    if (s_idx[18] !== 3'd4) begin
      errs++; $display("FAIL zero_last_index got %0d exp 4", s_idx[18]);
    end
  endtask

  task automatic test_space_invalid();
    sel = 1'b0;
    send(8'h20);
    capture(8);
    vecs++;
    if (s_busy[7:0] !== 8'h7F) begin
      errs++; $display("FAIL space_busy got %b exp 01111111", s_busy[7:0]);
    end
    vecs++;
    if (s_key[7:0] !== 8'h00) begin
      errs++; $display("FAIL space_key got %b exp 00000000", s_key[7:0]);
    end
    send(8'h3F);
    capture(3);
    vecs++;
    if (s_inv[2:0] !== 3'b001) begin
      errs++; $display("FAIL qmark_invalid got %b exp 001", s_inv[2:0]);
    end
    vecs++;
    if ({s_rdy[2:0], s_key[2:0], s_busy[2:0]} !== 9'b111000000) begin
      errs++; $display("FAIL qmark_ready_key_busy got %b exp 111000000",
                       {s_rdy[2:0], s_key[2:0], s_busy[2:0]});
    end
  endtask

  task automatic test_reset_mid_char();
    sel = 1'b0;
    send(8'h54);
    capture(3);
    vecs++;
    if (s_key[2] !== 1'b1) begin
      errs++; $display("FAIL midT_key_before_reset got %b exp 1", s_key[2]);
    end
    #2;
    reset = 1'b0;
    #1;
    vecs++;
    if ({key1, busy1} !== 2'b00) begin
      errs++; $display("FAIL async_reset_key_busy got %b exp 00", {key1, busy1});
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send(8'h45);
    capture(7);
    vecs++;
    if (s_key[6:0] !== 7'b0000100) begin
      errs++; $display("FAIL E_after_reset_key got %b exp 0000100", s_key[6:0]);
    end
    vecs++;
    if (s_rdy[6:0] !== 7'b1000000) begin
      errs++; $display("FAIL E_after_reset_ready got %b exp 1000000", s_rdy[6:0]);
    end
  endtask

  initial begin
    test_reset();
    test_letter_e();
    test_letter_s();
    test_unit4_t();
    test_digit_zero();
    test_space_invalid();
    test_reset_mid_char();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
